p_inject_arbiter: RTL and testbench

- Shares one router local (P) injection port among NUM_SRC local sources (processing elements or DMA engines).
- Round-robin arbitration at packet granularity: a grant is held from head flit to tail flit, so packets stay contiguous (wormhole).
- Sits between the sources and the router's P_datain/P_reqin/P_ackout. Adds one output register stage, a packet counter and a malformed-packet error flag.

---
 rtl/p_inject_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_p_inject_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_inject_arbiter.sv
// Round-robin, packet-granular arbiter sharing one router P injection port among NUM_SRC sources.
// Registered output stage, delivered-packet counter and sticky malformed-framing flag.
//   state | meaning
//   IDLE  | no packet open; arbitrate heads/singles from rr_ptr
//   LOCK  | owner holds the port until its tail is accepted
module p_inject_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int FLIT_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_reqin,
    output logic [NUM_SRC-1:0]        src_ackout,
    input  logic [NUM_SRC*FLIT_W-1:0] src_datain,
    output logic                      inj_reqout,
    input  logic                      inj_ackin,
    output logic [FLIT_W-1:0]         inj_dataout,
    output logic [2:0]                owner,
    output logic                      busy,
    output logic                      err,
    output logic [CNT_W-1:0]          pkt_cnt
);

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         owner_q, owner_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic               err_q, err_d;
    logic               out_vld_q;
    logic [FLIT_W-1:0]  out_data_q;
    logic [CNT_W-1:0]   pkt_cnt_q;

    logic [FLIT_W-1:0]  flit [NUM_SRC];
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] stray;
    logic               space;
    logic               cand_vld, stray_vld;
    logic [2:0]         cand_idx, stray_idx;
    logic [FLIT_W-1:0]  cand_flit, own_flit;
    logic               own_req;
    logic               ack_en;
    logic [2:0]         ack_idx;
    logic               load;
    logic [FLIT_W-1:0]  load_data;

    // First set bit of vec at or after ptr, wrapping; returns {found, index}.
    function automatic logic [3:0] pick(input logic [NUM_SRC-1:0] vec, input logic [2:0] ptr);
        logic       found;
        logic [2:0] idx;
        int         pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_SRC) pos = pos - NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && pos == i && vec[i]) begin
                    found = 1'b1;
                    idx   = 3'(i);
                end
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [2:0] nxt(input logic [2:0] i);
        if (i >= 3'(NUM_SRC - 1)) return 3'd0;
        return i + 3'd1;
    endfunction

    // Type bit FLIT_W-2 is set for head and single: the only flits that may open a grant.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign flit[g]  = src_datain[g*FLIT_W +: FLIT_W];
        assign cand[g]  = src_reqin[g] &&  flit[g][FLIT_W-2];
        assign stray[g] = src_reqin[g] && !flit[g][FLIT_W-2];
    end

    assign space = !out_vld_q || inj_ackin;
    assign {cand_vld, cand_idx}   = pick(cand, rr_ptr_q);
    assign {stray_vld, stray_idx} = pick(stray, rr_ptr_q);

    always_comb begin
        own_req   = 1'b0;
        own_flit  = '0;
        cand_flit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (3'(i) == owner_q) begin
                own_req  = src_reqin[i];
                own_flit = flit[i];
            end
            if (3'(i) == cand_idx) cand_flit = flit[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q;
        ack_en    = 1'b0;
        ack_idx   = owner_q;
        load      = 1'b0;
        load_data = own_flit;
        case (state_q)
            S_IDLE: begin
                ack_idx   = cand_idx;
                load_data = cand_flit;
                if (cand_vld) begin
                    if (space) begin
                        ack_en = 1'b1;
                        load   = 1'b1;
                        if (cand_flit[FLIT_W-1 -: 2] == T_HEAD) begin
                            state_d = S_LOCK;
                            owner_d = cand_idx;
                        end else begin
                            rr_ptr_d = nxt(cand_idx);
                        end
                    end
                end else if (stray_vld) begin
                    // Orphan body/tail is swallowed so its source cannot stall forever.
                    ack_en  = 1'b1;
                    ack_idx = stray_idx;
                    err_d   = 1'b1;
                end
            end
            S_LOCK: begin
                if (own_req && space) begin
                    ack_en = 1'b1;
                    load   = 1'b1;
                    case (own_flit[FLIT_W-1 -: 2])
                        T_BODY: ;
                        T_TAIL: begin
                            state_d  = S_IDLE;
                            rr_ptr_d = nxt(owner_q);
                        end
                        default: begin
                            err_d    = 1'b1;
                            state_d  = S_IDLE;
                            rr_ptr_d = nxt(owner_q);
                        end
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        src_ackout = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ackout[i] = rst && ack_en && (3'(i) == ack_idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            if (load) begin
                out_vld_q  <= 1'b1;
                out_data_q <= load_data;
            end else if (inj_ackin) begin
                out_vld_q  <= 1'b0;
            end
            if (out_vld_q && inj_ackin && out_data_q[FLIT_W-1]) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
        end
    end

    assign inj_reqout  = out_vld_q;
    assign inj_dataout = out_data_q;
    assign owner       = owner_q;
    assign busy        = (state_q == S_LOCK);
    assign err         = err_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_p_inject_arbiter.sv
// Scoreboard bench for p_inject_arbiter: per-source flit queues drive the sources,
// expected router-side flits are queued by each test and popped when the router accepts.
module tb_p_inject_arbiter;

    localparam int NUM_SRC = 4;
    localparam int FLIT_W  = 32;
    localparam int CNT_W   = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC-1:0]        src_reqin;
    logic [NUM_SRC-1:0]        src_ackout;
    logic [NUM_SRC*FLIT_W-1:0] src_datain;
    logic                      inj_reqout;
    logic                      inj_ackin;
    logic [FLIT_W-1:0]         inj_dataout;
    logic [2:0]                owner;
    logic                      busy;
    logic                      err;
    logic [CNT_W-1:0]          pkt_cnt;

    p_inject_arbiter #(.NUM_SRC(NUM_SRC), .FLIT_W(FLIT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_reqin   (src_reqin),
        .src_ackout  (src_ackout),
        .src_datain  (src_datain),
        .inj_reqout  (inj_reqout),
        .inj_ackin   (inj_ackin),
        .inj_dataout (inj_dataout),
        .owner       (owner),
        .busy        (busy),
        .err         (err),
        .pkt_cnt     (pkt_cnt)
    );

    logic [31:0]        src_mem [NUM_SRC][32];
    int                 src_rd [NUM_SRC];
    int                 src_wr [NUM_SRC];
    logic [31:0]        exp_q[$];
    int                 ack_src[$];
    int                 ack_cyc[$];
    int                 out_cyc[$];
    logic [NUM_SRC-1:0] ack_s;
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 cyc     = 0;
    int                 busy_cnt = 0;
    bit                 reqout_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic push_src(input int s, input logic [31:0] d);
        src_mem[s][src_wr[s] % 32] = d;
        src_wr[s]++;
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < NUM_SRC; i++) if (src_rd[i] != src_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clr_logs();
        ack_src.delete();
        ack_cyc.delete();
        out_cyc.delete();
        busy_cnt    = 0;
        reqout_seen = 0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            step();
            n++;
            done = (exp_q.size() == 0) && !inj_reqout && srcs_empty();
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < NUM_SRC; i++) src_rd[i] = src_wr[i];
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        clr_logs();
    endtask

    // Source driver: a source drops its head flit after an accepting edge.
    initial begin
        src_reqin  = '0;
        src_datain = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rst && ack_s[i]) src_rd[i]++;
                if (src_rd[i] < src_wr[i]) begin
                    src_reqin[i] = 1'b1;
                    src_datain[i*FLIT_W +: FLIT_W] = src_mem[i][src_rd[i] % 32];
                end else begin
                    src_reqin[i] = 1'b0;
                    src_datain[i*FLIT_W +: FLIT_W] = '0;
                end
            end
        end
    end

    // Monitor: samples mid-cycle, logs accepts, checks router-side flits against the scoreboard.
    initial begin
        ack_s = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ack_onehot", 32'($countones(src_ackout) <= 1), 32'd1);
                ack_s = src_ackout & src_reqin;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (ack_s[i]) begin
                        ack_src.push_back(i);
                        ack_cyc.push_back(cyc);
                    end
                end
                if (inj_reqout) reqout_seen = 1'b1;
                if (busy) busy_cnt++;
                if (inj_reqout && inj_ackin) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_extra_flit", 32'(exp_q.size()), 32'd1);
                    end else begin
                        chk("sb_flit", inj_dataout, exp_q.pop_front());
                        out_cyc.push_back(cyc);
                    end
                end
            end else begin
                ack_s = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord2 [6];
        int ord4 [8];
        rst       = 1'b0;
        inj_ackin = 1'b0;

        // Reset state, with a head presented so the ack gating is exercised.
        push_src(0, 32'h4000_00F0);
        step();
        @(negedge clk);
        #1;
        chk("rst_src_req", 32'(src_reqin), 32'd1);
        chk("rst_ackout", 32'(src_ackout), 32'd0);
        chk("rst_reqout", 32'(inj_reqout), 32'd0);
        chk("rst_dataout", inj_dataout, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        src_rd[0] = src_wr[0];
        step();
        step();
        rst       = 1'b1;
        inj_ackin = 1'b1;
        clr_logs();

        // Single source, three-flit packet.
        push_src(0, 32'h4000_0001); exp_q.push_back(32'h4000_0001);
        push_src(0, 32'h0000_0002); exp_q.push_back(32'h0000_0002);
        push_src(0, 32'h8000_0003); exp_q.push_back(32'h8000_0003);
        wait_drain("t1_drain");
        chk("t1_nacks", 32'(ack_src.size()), 32'd3);
        chk("t1_nout", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3 && ack_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("t1_latency", 32'(out_cyc[k]), 32'(ack_cyc[k] + 1));
            chk("t1_b2b_a", 32'(out_cyc[1]), 32'(out_cyc[0] + 1));
            chk("t1_b2b_b", 32'(out_cyc[2]), 32'(out_cyc[1] + 1));
        end
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Pointer now sits at 1: src1 must beat src0.
        clr_logs();
        push_src(0, 32'hC000_0100);
        push_src(1, 32'hC000_0101);
        exp_q.push_back(32'hC000_0101);
        exp_q.push_back(32'hC000_0100);
        wait_drain("t1_rr_drain");
        chk("t1_rr_first", 32'(ack_src.size() > 0 ? ack_src[0] : -1), 32'd1);

        // Contention from rr_ptr 0: src1 packet completes before src2 starts.
        do_reset();
        push_src(1, 32'h4000_0011); push_src(1, 32'h0000_0012);
        push_src(1, 32'h0000_0013); push_src(1, 32'h8000_0014);
        push_src(2, 32'h4000_0021); push_src(2, 32'h8000_0022);
        exp_q.push_back(32'h4000_0011); exp_q.push_back(32'h0000_0012);
        exp_q.push_back(32'h0000_0013); exp_q.push_back(32'h8000_0014);
        exp_q.push_back(32'h4000_0021); exp_q.push_back(32'h8000_0022);
        ord2 = '{1, 1, 1, 1, 2, 2};
        wait_drain("t2_drain");
        chk("t2_nacks", 32'(ack_src.size()), 32'd6);
        if (ack_src.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("t2_order", 32'(ack_src[k]), 32'(ord2[k]));
            chk("t2_handover", 32'(ack_cyc[4]), 32'(ack_cyc[3] + 1));
        end
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Router backpressure for five cycles with body 0x32 in the output register.
        clr_logs();
        push_src(0, 32'h4000_0031); push_src(0, 32'h0000_0032);
        push_src(0, 32'h0000_0033); push_src(0, 32'h8000_0034);
        exp_q.push_back(32'h4000_0031); exp_q.push_back(32'h0000_0032);
        exp_q.push_back(32'h0000_0033); exp_q.push_back(32'h8000_0034);
        for (int n = 0; n < 50 && ack_src.size() < 2; n++) @(posedge clk);
        chk("t3_reach_body", 32'(ack_src.size()), 32'd2);
        #3;
        inj_ackin = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("t3_hold_data", inj_dataout, 32'h0000_0032);
            chk("t3_hold_vld", 32'(inj_reqout), 32'd1);
            chk("t3_no_ack", 32'(src_ackout), 32'd0);
        end
        step();
        inj_ackin = 1'b1;
        wait_drain("t3_drain");
        chk("t3_nacks", 32'(ack_src.size()), 32'd4);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // Fairness: all four sources stream single flits.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                push_src(i, 32'hC000_0000 + 32'(i));
                exp_q.push_back(32'hC000_0000 + 32'(i));
            end
        end
        ord4 = '{0, 1, 2, 3, 0, 1, 2, 3};
        wait_drain("t4_drain");
        chk("t4_nacks", 32'(ack_src.size()), 32'd8);
        if (ack_src.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("t4_order", 32'(ack_src[k]), 32'(ord4[k]));
        end
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd8);

        // Orphan body while idle: acked, dropped, err set and sticky.
        clr_logs();
        chk("t5_err_before", 32'(err), 32'd0);
        push_src(3, 32'h0000_00AA);
        repeat (6) step();
        chk("t5_nacks", 32'(ack_src.size()), 32'd1);
        chk("t5_ack_src", 32'(ack_src.size() > 0 ? ack_src[0] : -1), 32'd3);
        chk("t5_not_fwd", 32'(reqout_seen), 32'd0);
        chk("t5_err", 32'(err), 32'd1);
        repeat (4) step();
        chk("t5_err_sticky", 32'(err), 32'd1);
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd8);

        // Reset in the middle of a packet, then a fresh packet from src2.
        clr_logs();
        push_src(0, 32'h4000_0061); push_src(0, 32'h0000_0062); push_src(0, 32'h8000_0063);
        exp_q.push_back(32'h4000_0061);
        for (int n = 0; n < 50 && ack_src.size() < 2; n++) @(posedge clk);
        chk("t6_reach_body", 32'(ack_src.size()), 32'd2);
        #3;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_reqout", 32'(inj_reqout), 32'd0);
        chk("t6_dataout", inj_dataout, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_ackout", 32'(src_ackout), 32'd0);
        for (int i = 0; i < NUM_SRC; i++) src_rd[i] = src_wr[i];
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        clr_logs();
        push_src(2, 32'h4000_0071); push_src(2, 32'h8000_0072);
        exp_q.push_back(32'h4000_0071); exp_q.push_back(32'h8000_0072);
        wait_drain("t6_drain");
        chk("t6_nacks", 32'(ack_src.size()), 32'd2);
        chk("t6_ack_src", 32'(ack_src.size() > 0 ? ack_src[0] : -1), 32'd2);
        chk("t6_pkt_cnt_after", 32'(pkt_cnt), 32'd1);
        chk("t6_err_after", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
